// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared encodings for the forwarding/hazard controller: operand source selects
// and controller state codes.
package fwd_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EXE = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_LU_STALL = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  // Load-use countdown width; LOAD_LAT is bounded to 1..15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/fwd_hazard_ctrl_src_mux.sv
// Priority forwarding mux for one operand: EXE > MEM > WB > register file.
// Register 0 never matches, so it always reads from the register file.
module fwd_src_mux
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int WB_FWD = 1
) (
  input  logic [REG_AW-1:0] src,
  input  logic              en,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              exe_ok,
  input  logic [REG_AW-1:0] exe_dest,
  input  logic [DATA_W-1:0] exe_result,
  input  logic              mem_ok,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_ok,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] data,
  output logic [1:0]        sel
);

  function automatic logic hit(input logic ok, input logic [REG_AW-1:0] dest,
                               input logic [REG_AW-1:0] s);
    return ok && (dest == s) && (|dest);
  endfunction

  always_comb begin
    sel  = FWD_RF;
    data = rf_data;
    if (en) begin
      if (hit(exe_ok, exe_dest, src)) begin
        sel  = FWD_EXE;
        data = exe_result;
      end else if (hit(mem_ok, mem_dest, src)) begin
        sel  = FWD_MEM;
        data = mem_result;
      end else if ((WB_FWD != 0) && hit(wb_ok, wb_dest, src)) begin
        sel  = FWD_WB;
        data = wb_result;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Operand forwarding, load-use stall/bubble generation, memory-wait freeze and
// a saturating count of lost cycles for the 5-stage pipeline.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int WB_FWD   = 1,
  parameter int STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_use2,
  input  logic              id_st_en,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  input  logic [REG_AW-1:0] exe_dest,
  input  logic              exe_wb_en,
  input  logic              exe_mem_r_en,
  input  logic [DATA_W-1:0] exe_result,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_wb_en,
  input  logic              mem_mem_r_en,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              mem_ready,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic              wb_wb_en,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] src1_out,
  output logic [DATA_W-1:0] src2_out,
  output logic [DATA_W-1:0] st_data_out,
  output logic [1:0]        fwd_sel1,
  output logic [1:0]        fwd_sel2,
  output logic              stall,
  output logic              bubble,
  output logic              freeze,
  output logic [STAT_W-1:0] stall_cnt
);

  logic [1:0]       state, state_n, saved, saved_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             boot;
  logic             exe_ok, mem_ok, hold, lu, exe_hit1, exe_hit2;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A load still in EXE has no data yet; a load in MEM only once the SRAM answers.
  assign exe_ok = exe_wb_en & ~exe_mem_r_en;
  assign mem_ok = mem_wb_en & ~(mem_mem_r_en & ~mem_ready);

  fwd_src_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .WB_FWD(WB_FWD)) u_mux1 (
    .src(id_src1), .en(1'b1), .rf_data(rf_data1),
    .exe_ok(exe_ok), .exe_dest(exe_dest), .exe_result(exe_result),
    .mem_ok(mem_ok), .mem_dest(mem_dest), .mem_result(mem_result),
    .wb_ok(wb_wb_en), .wb_dest(wb_dest), .wb_result(wb_result),
    .data(src1_out), .sel(fwd_sel1)
  );

  fwd_src_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .WB_FWD(WB_FWD)) u_mux2 (
    .src(id_src2), .en(id_use2), .rf_data(rf_data2),
    .exe_ok(exe_ok), .exe_dest(exe_dest), .exe_result(exe_result),
    .mem_ok(mem_ok), .mem_dest(mem_dest), .mem_result(mem_result),
    .wb_ok(wb_wb_en), .wb_dest(wb_dest), .wb_result(wb_result),
    .data(src2_out), .sel(fwd_sel2)
  );

  fwd_src_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .WB_FWD(WB_FWD)) u_mux_st (
    .src(id_src2), .en(id_st_en), .rf_data(rf_data2),
    .exe_ok(exe_ok), .exe_dest(exe_dest), .exe_result(exe_result),
    .mem_ok(mem_ok), .mem_dest(mem_dest), .mem_result(mem_result),
    .wb_ok(wb_wb_en), .wb_dest(wb_dest), .wb_result(wb_result),
    .data(st_data_out), .sel()
  );

  assign exe_hit1 = exe_wb_en && (exe_dest == id_src1) && (|exe_dest);
  assign exe_hit2 = exe_wb_en && (exe_dest == id_src2) && (|exe_dest);
  assign lu       = exe_mem_r_en & (exe_hit1 | ((id_use2 | id_st_en) & exe_hit2));
  assign hold     = mem_mem_r_en & ~mem_ready;

  // Outputs stay low during reset and the cycle after it (boot).
  always_comb begin
    state_n = state;
    saved_n = saved;
    cnt_n   = cnt;
    stall   = 1'b0;
    bubble  = 1'b0;
    freeze  = 1'b0;
    if (!(rst || boot)) begin
      case (state)
        ST_IDLE: begin
          if (hold) begin
            freeze  = 1'b1;
            saved_n = ST_IDLE;
            state_n = ST_MEM_WAIT;
          end else if (lu) begin
            stall  = 1'b1;
            bubble = 1'b1;
            if (LOAD_LAT > 1) begin
              cnt_n   = CNT_W'(LOAD_LAT - 1);
              state_n = ST_LU_STALL;
            end
          end
        end
        ST_LU_STALL: begin
          if (hold) begin
            freeze  = 1'b1;
            saved_n = ST_LU_STALL;
            state_n = ST_MEM_WAIT;
          end else begin
            stall  = 1'b1;
            bubble = 1'b1;
            cnt_n  = cnt - 1'b1;
            if (cnt == CNT_W'(1)) state_n = ST_IDLE;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ready) state_n = saved;
          else           freeze  = 1'b1;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      saved     <= ST_IDLE;
      cnt       <= '0;
      boot      <= 1'b1;
      stall_cnt <= '0;
    end else begin
      state <= state_n;
      saved <= saved_n;
      cnt   <= cnt_n;
      boot  <= 1'b0;
      if (stall | freeze) stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl (LOAD_LAT=3, STAT_W=4, WB forwarding on).
module tb_fwd_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_src1, id_src2, exe_dest, mem_dest, wb_dest;
  logic        id_use2, id_st_en, exe_wb_en, exe_mem_r_en;
  logic        mem_wb_en, mem_mem_r_en, mem_ready, wb_wb_en;
  logic [31:0] rf_data1, rf_data2, exe_result, mem_result, wb_result;
  logic [31:0] src1_out, src2_out, st_data_out;
  logic [1:0]  fwd_sel1, fwd_sel2;
  logic        stall, bubble, freeze;
  logic [3:0]  stall_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(
    .DATA_W(32), .REG_AW(5), .LOAD_LAT(3), .WB_FWD(1), .STAT_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_use2(id_use2), .id_st_en(id_st_en),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .exe_result(exe_result),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_mem_r_en(mem_mem_r_en),
    .mem_result(mem_result), .mem_ready(mem_ready),
    .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .wb_result(wb_result),
    .src1_out(src1_out), .src2_out(src2_out), .st_data_out(st_data_out),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .stall(stall), .bubble(bubble), .freeze(freeze), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    id_src1 = 0; id_src2 = 0; id_use2 = 0; id_st_en = 0;
    rf_data1 = 0; rf_data2 = 0;
    exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0; exe_result = 0;
    mem_dest = 0; mem_wb_en = 0; mem_mem_r_en = 0; mem_result = 0; mem_ready = 1;
    wb_dest = 0; wb_wb_en = 0; wb_result = 0;
  endtask

  task automatic load_in_exe(input logic [4:0] r);
    exe_dest = r; exe_wb_en = 1; exe_mem_r_en = 1; exe_result = 32'hDEAD;
    id_src1 = r;
  endtask

  task automatic load_to_mem(input logic [4:0] r, input logic [31:0] d, input logic rdy);
    exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0;
    mem_dest = r; mem_wb_en = 1; mem_mem_r_en = 1; mem_result = d; mem_ready = rdy;
  endtask

  initial begin
    clear();
    rst = 1;
    cyc(); cyc();
    // Reset cycle and the one after it: outputs masked even with hazards present.
    load_in_exe(5'd4);
    mem_mem_r_en = 1; mem_ready = 0;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_freeze", freeze, 0);
    chk("rst_bubble", bubble, 0);
    chk("rst_cnt", stall_cnt, 0);
    rst = 0;
    #1;
    chk("boot_stall", stall, 0);
    chk("boot_freeze", freeze, 0);
    cyc();
    clear();
    #1;
    chk("boot_cnt", stall_cnt, 0);
    cyc();

    // Test 1: EXE forwarding and register 0
    exe_dest = 5; exe_wb_en = 1; exe_result = 32'hA; id_src1 = 5; rf_data1 = 32'h99;
    #1;
    chk("t1_src1", src1_out, 32'hA);
    chk("t1_sel1", fwd_sel1, 1);
    chk("t1_stall", stall, 0);
    exe_dest = 0; id_src1 = 0; rf_data1 = 0;
    #1;
    chk("t1_r0_sel1", fwd_sel1, 0);
    chk("t1_r0_src1", src1_out, 0);
    cyc();

    // Test 2: priority and id_use2 / store data gating
    clear();
    exe_dest = 7; exe_wb_en = 1; exe_result = 32'h11;
    mem_dest = 7; mem_wb_en = 1; mem_result = 32'h22;
    wb_dest = 7; wb_wb_en = 1; wb_result = 32'h44;
    id_src2 = 7; id_use2 = 1; rf_data2 = 32'h33;
    #1;
    chk("t2_src2_exe", src2_out, 32'h11);
    chk("t2_sel2_exe", fwd_sel2, 1);
    id_use2 = 0;
    #1;
    chk("t2_src2_nouse", src2_out, 32'h33);
    chk("t2_sel2_nouse", fwd_sel2, 0);
    id_use2 = 1; exe_wb_en = 0;
    #1;
    chk("t2_src2_mem", src2_out, 32'h22);
    chk("t2_sel2_mem", fwd_sel2, 2);
    mem_wb_en = 0;
    #1;
    chk("t2_sel2_wb", fwd_sel2, 3);
    id_use2 = 0; id_st_en = 1;
    #1;
    chk("t2_st_wb", st_data_out, 32'h44);
    chk("t2_src2_st_nouse", src2_out, 32'h33);
    cyc();

    // Test 3: load-use stall lasts exactly LOAD_LAT=3 cycles
    clear();
    load_in_exe(5'd4); rf_data1 = 32'h1;
    #1;
    chk("t3_c1_stall", stall, 1);
    chk("t3_c1_bubble", bubble, 1);
    chk("t3_c1_sel1_rf", fwd_sel1, 0);
    cyc();
    load_to_mem(5'd4, 32'h55, 1'b1);
    #1;
    chk("t3_c2_stall", stall, 1);
    chk("t3_c2_sel1", fwd_sel1, 2);
    cyc(); #1;
    chk("t3_c3_stall", stall, 1);
    chk("t3_c3_bubble", bubble, 1);
    cyc(); #1;
    chk("t3_c4_stall", stall, 0);
    chk("t3_c4_bubble", bubble, 0);
    chk("t3_cnt", stall_cnt, 3);
    cyc();

    // Test 4: MEM load not ready for 4 cycles -> freeze 4 cycles
    clear();
    load_to_mem(5'd9, 32'h77, 1'b0);
    id_src1 = 9; rf_data1 = 32'h1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_freeze", freeze, 1);
      chk("t4_stall", stall, 0);
      chk("t4_sel1_rf", fwd_sel1, 0);
      cyc();
    end
    mem_ready = 1;
    #1;
    chk("t4_rel_freeze", freeze, 0);
    chk("t4_rel_sel1", fwd_sel1, 2);
    chk("t4_rel_src1", src1_out, 32'h77);
    cyc();
    clear();
    #1;
    chk("t4_cnt", stall_cnt, 7);
    cyc();

    // Test 5: freeze at cnt=1 inside the load-use stall
    load_in_exe(5'd4);
    #1; chk("t5_c1_stall", stall, 1);
    cyc();
    load_to_mem(5'd4, 32'h66, 1'b1);
    #1; chk("t5_c2_stall", stall, 1);
    cyc();
    mem_ready = 0;
    #1;
    chk("t5_c3_freeze", freeze, 1);
    chk("t5_c3_stall", stall, 0);
    chk("t5_c3_bubble", bubble, 0);
    cyc(); #1;
    chk("t5_c4_freeze", freeze, 1);
    cyc();
    mem_ready = 1;
    #1;
    chk("t5_c5_freeze", freeze, 0);
    chk("t5_c5_stall", stall, 0);
    cyc(); #1;
    chk("t5_c6_stall", stall, 1);
    chk("t5_c6_freeze", freeze, 0);
    cyc(); #1;
    chk("t5_c7_stall", stall, 0);
    chk("t5_cnt", stall_cnt, 12);
    cyc();

    // Test 6: reset mid LU_STALL, then saturation of the 4-bit counter
    clear();
    load_in_exe(5'd3);
    #1; chk("t6_c1_stall", stall, 1);
    cyc();
    load_to_mem(5'd3, 32'h5, 1'b1);
    #1; chk("t6_c2_stall", stall, 1);
    rst = 1;
    #1; chk("t6_rst_stall", stall, 0);
    cyc();
    rst = 0;
    #1;
    chk("t6_after_stall", stall, 0);
    chk("t6_after_bubble", bubble, 0);
    chk("t6_after_cnt", stall_cnt, 0);
    cyc(); #1;
    chk("t6_idle_stall", stall, 0);
    clear();
    cyc();
    mem_mem_r_en = 1; mem_wb_en = 1; mem_dest = 2; mem_ready = 0;
    for (int i = 0; i < 14; i++) cyc();
    #1;
    chk("t6_cnt14", stall_cnt, 14);
    chk("t6_freeze_held", freeze, 1);
    for (int i = 0; i < 6; i++) cyc();
    #1;
    chk("t6_sat", stall_cnt, 15);
    mem_ready = 1;
    cyc(); #1;
    chk("t6_sat_hold", stall_cnt, 15);
    chk("t6_sat_freeze", freeze, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
